// File: rtl/dmem_sized_if.sv
// Request/response bus for dmem_sized: valid/ready request channel carrying
// a sized, byte-addressed access and a valid/ready response channel.
interface dmem_sized_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_sized.sv
// Big-endian byte-addressed data memory with byte/half/word access and a fixed number
// of wait states. Define DMEM_ALIGN_CHECK_EN to reject misaligned half/word accesses.
module dmem_sized #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic         clk,
    input  logic         reset,
    dmem_sized_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic        r_write;
    logic        r_signed;
    logic [31:0] r_wdata;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;

    logic [7:0]  r_mem [DEPTH];

    // With zero wait states the access executes on the accept edge, so decode
    // straight from the bus while idle and from the latched copy otherwise.
    logic        w_idle;
    logic [31:0] w_addr;
    logic [1:0]  w_size;
    logic        w_write;
    logic        w_signed;
    logic [31:0] w_wdata;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_addr   = w_idle ? bus.req_addr   : r_addr;
    assign w_size   = w_idle ? bus.req_size   : r_size;
    assign w_write  = w_idle ? bus.req_write  : r_write;
    assign w_signed = w_idle ? bus.req_signed : r_signed;
    assign w_wdata  = w_idle ? bus.req_wdata  : r_wdata;

    logic [1:0]        w_nbytes_m1;
    logic [ADDR_W:0]   w_end;
    logic              w_range_err;
    logic              w_err;
    logic [ADDR_W-1:0] w_base;

    always_comb begin
        w_nbytes_m1 = 2'd0;
        case (w_size)
            2'b01:   w_nbytes_m1 = 2'd1;
            2'b10:   w_nbytes_m1 = 2'd3;
            default: w_nbytes_m1 = 2'd0;
        endcase
    end

    // Range is judged on the address as issued, before any aligning-down.
    assign w_end       = {1'b0, w_addr[ADDR_W-1:0]} + (ADDR_W+1)'(w_nbytes_m1);
    assign w_range_err = (|w_addr[31:ADDR_W]) | w_end[ADDR_W];

`ifdef DMEM_ALIGN_CHECK_EN
    logic w_misalign;
    assign w_misalign = ((w_size == 2'b01) & w_addr[0]) | ((w_size == 2'b10) & (|w_addr[1:0]));
    assign w_err      = (w_size == 2'b11) | w_range_err | w_misalign;
    assign w_base     = w_addr[ADDR_W-1:0];
`else
    assign w_err  = (w_size == 2'b11) | w_range_err;
    assign w_base = (w_size == 2'b10) ? {w_addr[ADDR_W-1:2], 2'b00} :
                    (w_size == 2'b01) ? {w_addr[ADDR_W-1:1], 1'b0}  :
                                        w_addr[ADDR_W-1:0];
`endif

    // Store data left-justified so byte lane gi always takes bits [31-8*gi -: 8].
    logic [31:0] w_wdata_be;
    always_comb begin
        w_wdata_be = w_wdata;
        case (w_size)
            2'b00:   w_wdata_be = {w_wdata[7:0], 24'd0};
            2'b01:   w_wdata_be = {w_wdata[15:0], 16'd0};
            default: w_wdata_be = w_wdata;
        endcase
    end

    logic              w_exec;
    logic [ADDR_W-1:0] w_lane_addr [4];
    logic [7:0]        w_lane_rd   [4];
    logic [7:0]        w_lane_wd   [4];
    logic [3:0]        w_lane_we;

    assign w_exec = ~reset &
                    ((w_idle & bus.req_valid & (WAIT_STATES == 0)) |
                     ((r_state == ST_WAIT) & (r_cnt == 4'd1)));

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_lane_addr[gi] = w_base + ADDR_W'(gi);
            assign w_lane_rd[gi]   = r_mem[w_lane_addr[gi]];
            assign w_lane_wd[gi]   = w_wdata_be[31-8*gi -: 8];
            assign w_lane_we[gi]   = w_exec & w_write & ~w_err & (2'(gi) <= w_nbytes_m1);
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (w_lane_we[i]) begin
                r_mem[w_lane_addr[i]] <= w_lane_wd[i];
            end
        end
    end

    logic [31:0] w_word_be;
    logic [31:0] w_load;
    logic [31:0] w_rsp_rdata;

    assign w_word_be = {w_lane_rd[0], w_lane_rd[1], w_lane_rd[2], w_lane_rd[3]};

    always_comb begin
        w_load = w_word_be;
        case (w_size)
            2'b00:   w_load = {{24{w_signed & w_word_be[31]}}, w_word_be[31:24]};
            2'b01:   w_load = {{16{w_signed & w_word_be[31]}}, w_word_be[31:16]};
            default: w_load = w_word_be;
        endcase
    end

    assign w_rsp_rdata = (w_err | w_write) ? 32'd0 : w_load;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_addr      <= 32'd0;
            r_size      <= 2'd0;
            r_write     <= 1'b0;
            r_signed    <= 1'b0;
            r_wdata     <= 32'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_addr   <= bus.req_addr;
                        r_size   <= bus.req_size;
                        r_write  <= bus.req_write;
                        r_signed <= bus.req_signed;
                        r_wdata  <= bus.req_wdata;
                        if (WAIT_STATES == 0) begin
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= w_rsp_rdata;
                            r_rsp_err   <= w_err;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= 4'(WAIT_STATES);
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 4'd1) begin
                        r_state     <= ST_RESP;
                        r_cnt       <= 4'd0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= w_rsp_rdata;
                        r_rsp_err   <= w_err;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        r_state     <= ST_IDLE;
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready = w_idle & ~reset;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;
endmodule

// File: tb/tb_dmem_sized.sv
// Directed bench for dmem_sized (ADDR_W=8, WAIT_STATES=1); expectations follow the
// big-endian byte map and track whether DMEM_ALIGN_CHECK_EN is defined.
module tb_dmem_sized;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    dmem_sized_if bus();

    dmem_sized #(.ADDR_W(8), .WAIT_STATES(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic txn(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er, output int lat);
        int n;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_write  = w;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        bus.rsp_ready  = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            bus.req_valid = 1'b0;
            rd  = 'x;
            er  = 1'bx;
            lat = -1;
            return;
        end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.rsp_valid && lat < 40);
        rd = bus.rsp_rdata;
        er = bus.rsp_err;
        if (!bus.rsp_valid) begin
            rd = 'x;
            er = 1'bx;
        end
        @(posedge clk);
        #1;
        $display("txn w=%0b sz=%0d sg=%0b addr=%h wdata=%h -> rdata=%h err=%0b lat=%0d",
                 w, sz, sg, a, wd, rd, er, lat);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          n;
        logic [31:0] exp10;
        logic        exp_err;

        reset          = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        bus.rsp_ready  = 1'b0;
        #3;
        check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("rst_rsp_err",   {31'd0, bus.rsp_err}, 32'd0);
        check("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_rst_req_ready", {31'd0, bus.req_ready}, 32'd1);

        txn(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat);
        check("st_w10_err", {31'd0, er}, 32'd0);
        check("st_w10_rdata", rd, 32'd0);
        txn(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, rd, er, lat);
        check("ld_w10", rd, 32'hDEADBEEF);
        check("ld_w10_err", {31'd0, er}, 32'd0);
        check("ld_w10_latency", 32'(lat), 32'd2);

        txn(1'b0, 2'b00, 1'b1, 32'h11, 32'd0, rd, er, lat);
        check("ld_b11_s", rd, 32'hFFFFFFAD);
        txn(1'b0, 2'b00, 1'b0, 32'h11, 32'd0, rd, er, lat);
        check("ld_b11_u", rd, 32'h000000AD);
        txn(1'b0, 2'b01, 1'b1, 32'h12, 32'd0, rd, er, lat);
        check("ld_h12_s", rd, 32'hFFFFBEEF);
        txn(1'b0, 2'b01, 1'b0, 32'h10, 32'd0, rd, er, lat);
        check("ld_h10_u", rd, 32'h0000DEAD);

        txn(1'b1, 2'b00, 1'b0, 32'h13, 32'hAAAAAA55, rd, er, lat);
        check("st_b13_err", {31'd0, er}, 32'd0);
        txn(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, rd, er, lat);
        check("ld_w10_after_b", rd, 32'hDEADBE55);

        txn(1'b0, 2'b10, 1'b0, 32'hFE, 32'd0, rd, er, lat);
        check("ld_wFE_err", {31'd0, er}, 32'd1);
        check("ld_wFE_rdata", rd, 32'd0);
        txn(1'b0, 2'b11, 1'b0, 32'h10, 32'd0, rd, er, lat);
        check("size11_err", {31'd0, er}, 32'd1);
        check("size11_rdata", rd, 32'd0);
        txn(1'b0, 2'b00, 1'b0, 32'h100, 32'd0, rd, er, lat);
        check("ld_b100_err", {31'd0, er}, 32'd1);

        txn(1'b1, 2'b00, 1'b0, 32'hFF, 32'h0000007E, rd, er, lat);
        check("st_bFF_err", {31'd0, er}, 32'd0);
        txn(1'b0, 2'b00, 1'b1, 32'hFF, 32'd0, rd, er, lat);
        check("ld_bFF_s", rd, 32'h0000007E);
        txn(1'b0, 2'b01, 1'b0, 32'hFF, 32'd0, rd, er, lat);
        check("ld_hFF_err", {31'd0, er}, 32'd1);
        check("ld_hFF_rdata", rd, 32'd0);

        txn(1'b0, 2'b01, 1'b0, 32'h11, 32'd0, rd, er, lat);
`ifdef DMEM_ALIGN_CHECK_EN
        check("ld_h11_err", {31'd0, er}, 32'd1);
        check("ld_h11_rdata", rd, 32'd0);
`else
        check("ld_h11_err", {31'd0, er}, 32'd0);
        check("ld_h11_rdata", rd, 32'h0000DEAD);
`endif

        txn(1'b1, 2'b10, 1'b0, 32'h12, 32'h12345678, rd, er, lat);
`ifdef DMEM_ALIGN_CHECK_EN
        exp_err = 1'b1;
        exp10   = 32'hDEADBE55;
`else
        exp_err = 1'b0;
        exp10   = 32'h12345678;
`endif
        check("st_w12_err", {31'd0, er}, {31'd0, exp_err});
        txn(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, rd, er, lat);
        check("ld_w10_after_w12", rd, exp10);

        // Backpressure: response held for three cycles while a store is offered.
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b0;
        bus.req_size   = 2'b10;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'h10;
        bus.rsp_ready  = 1'b0;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        n = 0;
        while (!bus.rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("bp_first_valid", {31'd0, bus.rsp_valid}, 32'd1);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_wdata = 32'h11111111;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("bp_valid",     {31'd0, bus.rsp_valid}, 32'd1);
            check("bp_rdata",     bus.rsp_rdata, exp10);
            check("bp_err",       {31'd0, bus.rsp_err}, 32'd0);
            check("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
            $display("backpressure cycle %0d rsp_valid=%0b rdata=%h", i, bus.rsp_valid, bus.rsp_rdata);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_done_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("bp_done_ready", {31'd0, bus.req_ready}, 32'd1);
        txn(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, rd, er, lat);
        check("bp_store_ignored", rd, exp10);

        // Reset during the wait cycle of a store drops it.
        txn(1'b1, 2'b10, 1'b0, 32'h20, 32'h01020304, rd, er, lat);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_size  = 2'b10;
        bus.req_addr  = 32'h20;
        bus.req_wdata = 32'hCAFEF00D;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_wait_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_wait_ready", {31'd0, bus.req_ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        $display("reset pulsed during store wait");
        txn(1'b0, 2'b10, 1'b0, 32'h20, 32'd0, rd, er, lat);
        check("ld_w20_after_rst", rd, 32'h01020304);

        // Reset during a pending load response clears the outputs at once.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 32'h20;
        bus.rsp_ready = 1'b0;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        n = 0;
        while (!bus.rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("resp_pending_rdata", bus.rsp_rdata, 32'h01020304);
        reset = 1'b1;
        #1;
        check("rst_resp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_resp_rdata", bus.rsp_rdata, 32'd0);
        check("rst_resp_err",   {31'd0, bus.rsp_err}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        bus.rsp_ready = 1'b1;
        $display("reset pulsed during load response");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
